// File: rtl/decode_issue_stage_if.sv
// Decode/issue stage bus: decode-side instruction, write-back port and ID/EX outputs.
// The stage itself connects through the slave modport.
interface decode_issue_stage_if #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int CTRL_W = 24
);
  localparam int AW = $clog2(NREGS);

  logic              in_valid;
  logic              in_ready;
  logic [31:0]       instr;
  logic [CTRL_W-1:0] ctrl_d;
  logic [XLEN-1:0]   imm_d;
  logic              rs1_used;
  logic              rs2_used;
  logic              rd_we_d;
  logic              is_load_d;

  logic              wb_en;
  logic [AW-1:0]     wb_addr;
  logic [XLEN-1:0]   wb_data;

  logic              flush;
  logic              out_ready;
  logic              out_valid;
  logic [CTRL_W-1:0] out_ctrl;
  logic [XLEN-1:0]   out_rs1_data;
  logic [XLEN-1:0]   out_rs2_data;
  logic [XLEN-1:0]   out_imm;
  logic [AW-1:0]     out_rs1_addr;
  logic [AW-1:0]     out_rs2_addr;
  logic [AW-1:0]     out_rd;
  logic              out_rd_we;
  logic              out_is_load;

  modport master (
    output in_valid, instr, ctrl_d, imm_d, rs1_used, rs2_used, rd_we_d, is_load_d,
    output wb_en, wb_addr, wb_data, flush, out_ready,
    input  in_ready, out_valid, out_ctrl, out_rs1_data, out_rs2_data, out_imm,
    input  out_rs1_addr, out_rs2_addr, out_rd, out_rd_we, out_is_load
  );

  modport slave (
    input  in_valid, instr, ctrl_d, imm_d, rs1_used, rs2_used, rd_we_d, is_load_d,
    input  wb_en, wb_addr, wb_data, flush, out_ready,
    output in_ready, out_valid, out_ctrl, out_rs1_data, out_rs2_data, out_imm,
    output out_rs1_addr, out_rs2_addr, out_rd, out_rd_we, out_is_load
  );
endinterface

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: register file with write-back bypass, load-use bubble, registered ID/EX.
// Optional perf counters are enabled by defining DECODE_PERF_CNT_EN.

// One combinational register read port; x0 reads zero, same-cycle write-back wins.
module dis_rd_port #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic [NREGS-1:0][XLEN-1:0] rf,
  input  logic [AW-1:0]              addr,
  input  logic                       wb_en,
  input  logic [AW-1:0]              wb_addr,
  input  logic [XLEN-1:0]            wb_data,
  output logic [XLEN-1:0]            data
);
  always_comb begin
    data = '0;
    if (addr != '0) begin
      if (wb_en && (wb_addr == addr)) data = wb_data;
      else                            data = rf[addr];
    end
  end
endmodule

module decode_issue_stage #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,  // 16 or 32
  parameter int CTRL_W = 24
) (
  input  logic clk,
  input  logic rst,
  decode_issue_stage_if.slave bus
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);
  localparam int AW = $clog2(NREGS);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [AW-1:0]     rs1_addr;
    logic [AW-1:0]     rs2_addr;
    logic [AW-1:0]     rd;
    logic              rd_we;
    logic              is_load;
  } idex_t;

  logic [NREGS-1:0][XLEN-1:0] rf;
  logic [1:0][AW-1:0]         rs_addr;
  logic [1:0][XLEN-1:0]       rs_data;
  logic [AW-1:0]              rd_addr;
  logic                       unused_instr;

  idex_t idex_q, idex_d;
  logic  vld_q;
  logic  advance, hazard, issue;

  // Opcode/funct bits are decoded upstream; only the register fields matter here.
  assign unused_instr = ^bus.instr;

  assign rs_addr[0] = bus.instr[15 +: AW];
  assign rs_addr[1] = bus.instr[20 +: AW];
  assign rd_addr    = bus.instr[7 +: AW];

  // x0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk) begin
    if (rst)                                   rf <= '0;
    else if (bus.wb_en && bus.wb_addr != '0)   rf[bus.wb_addr] <= bus.wb_data;
  end

  for (genvar p = 0; p < 2; p++) begin : gen_rd
    dis_rd_port #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) u_rd (
      .rf      (rf),
      .addr    (rs_addr[p]),
      .wb_en   (bus.wb_en),
      .wb_addr (bus.wb_addr),
      .wb_data (bus.wb_data),
      .data    (rs_data[p])
    );
  end

  assign advance = ~vld_q | bus.out_ready;
  assign hazard  = bus.in_valid & vld_q & idex_q.is_load & idex_q.rd_we & (idex_q.rd != '0) &
                   ((bus.rs1_used & (rs_addr[0] == idex_q.rd)) |
                    (bus.rs2_used & (rs_addr[1] == idex_q.rd)));
  assign issue   = advance & bus.in_valid & ~hazard;

  assign bus.in_ready = bus.flush | (advance & ~hazard);

  always_comb begin
    idex_d          = idex_q;
    idex_d.ctrl     = bus.ctrl_d;
    idex_d.rs1_data = rs_data[0];
    idex_d.rs2_data = rs_data[1];
    idex_d.imm      = bus.imm_d;
    idex_d.rs1_addr = rs_addr[0];
    idex_d.rs2_addr = rs_addr[1];
    idex_d.rd       = rd_addr;
    idex_d.rd_we    = bus.rd_we_d;
    idex_d.is_load  = bus.is_load_d;
  end

  // Flush outranks everything but reset; a held entry keeps tracking write-back so
  // its operands are not stale when execute finally takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      idex_q <= '0;
    end else if (bus.flush) begin
      vld_q <= 1'b0;
    end else if (advance) begin
      vld_q <= issue;
      if (issue) idex_q <= idex_d;
    end else begin
      if (bus.wb_en && bus.wb_addr != '0 && bus.wb_addr == idex_q.rs1_addr)
        idex_q.rs1_data <= bus.wb_data;
      if (bus.wb_en && bus.wb_addr != '0 && bus.wb_addr == idex_q.rs2_addr)
        idex_q.rs2_data <= bus.wb_data;
    end
  end

  assign bus.out_valid    = vld_q;
  assign bus.out_ctrl     = idex_q.ctrl;
  assign bus.out_rs1_data = idex_q.rs1_data;
  assign bus.out_rs2_data = idex_q.rs2_data;
  assign bus.out_imm      = idex_q.imm;
  assign bus.out_rs1_addr = idex_q.rs1_addr;
  assign bus.out_rs2_addr = idex_q.rs2_addr;
  assign bus.out_rd       = idex_q.rd;
  assign bus.out_rd_we    = idex_q.rd_we;
  assign bus.out_is_load  = idex_q.is_load;

`ifdef DECODE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (vld_q & ~bus.out_ready)            perf_stall_cnt  <= perf_stall_cnt + 32'd1;
      if (advance & hazard & ~bus.flush)     perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage: RAW, bypass, load-use, stall refresh, flush, NREGS=16.
module tb_decode_issue_stage;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  decode_issue_stage_if #(.XLEN(32), .NREGS(32), .CTRL_W(24)) dif ();
  decode_issue_stage_if #(.XLEN(32), .NREGS(16), .CTRL_W(24)) dif16 ();

`ifdef DECODE_PERF_CNT_EN
  logic [31:0] stall_cnt, bub_cnt, stall_cnt16, bub_cnt16;
`endif

  decode_issue_stage #(.XLEN(32), .NREGS(32), .CTRL_W(24)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
`ifdef DECODE_PERF_CNT_EN
    ,
    .perf_stall_cnt  (stall_cnt),
    .perf_bubble_cnt (bub_cnt)
`endif
  );

  decode_issue_stage #(.XLEN(32), .NREGS(16), .CTRL_W(24)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (dif16)
`ifdef DECODE_PERF_CNT_EN
    ,
    .perf_stall_cnt  (stall_cnt16),
    .perf_bubble_cnt (bub_cnt16)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b0, rd, 7'b0110011};
  endfunction

  task automatic set_in(input logic [31:0] i, input logic r1u, input logic r2u,
                        input logic rdwe, input logic ld, input logic [23:0] c, input logic [31:0] im);
    dif.instr     = i;
    dif.rs1_used  = r1u;
    dif.rs2_used  = r2u;
    dif.rd_we_d   = rdwe;
    dif.is_load_d = ld;
    dif.ctrl_d    = c;
    dif.imm_d     = im;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] a, input logic [31:0] d);
    dif.wb_en   = en;
    dif.wb_addr = a;
    dif.wb_data = d;
  endtask

  initial begin
    rst = 1'b1;
    dif.in_valid = 0; dif.flush = 0; dif.out_ready = 1;
    set_in('0, 0, 0, 0, 0, '0, '0);
    set_wb(0, '0, '0);
    dif16.in_valid = 0; dif16.flush = 0; dif16.out_ready = 1;
    dif16.instr = '0; dif16.ctrl_d = '0; dif16.imm_d = '0;
    dif16.rs1_used = 0; dif16.rs2_used = 0; dif16.rd_we_d = 0; dif16.is_load_d = 0;
    dif16.wb_en = 0; dif16.wb_addr = '0; dif16.wb_data = '0;

    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", dif.out_valid, 0);
    chk("rst_rs1", dif.out_rs1_data, 0);
    chk("rst_ctrl", dif.out_ctrl, 0);
    chk("rst_valid16", dif16.out_valid, 0);
`ifdef DECODE_PERF_CNT_EN
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_bub_cnt", bub_cnt, 0);
`endif

    // read-after-write through the register file
    set_wb(1, 5, 32'hAA);
    tick();
    set_wb(0, 0, 0);
    set_in(mk(1, 5, 0), 1, 1, 1, 0, 24'h123456, 32'h10);
    dif.in_valid = 1;
    #1 chk("raw_in_ready", dif.in_ready, 1);
    tick();
    chk("raw_valid", dif.out_valid, 1);
    chk("raw_rs1", dif.out_rs1_data, 32'hAA);
    chk("raw_rs2", dif.out_rs2_data, 0);
    chk("raw_ctrl", dif.out_ctrl, 24'h123456);
    chk("raw_imm", dif.out_imm, 32'h10);
    chk("raw_rd", dif.out_rd, 1);
    chk("raw_rs1_addr", dif.out_rs1_addr, 5);

    // same-cycle bypass, then x0 write ignored, then x7 readable from the file
    set_in(mk(2, 0, 7), 1, 1, 1, 0, 24'h1, 32'h0);
    set_wb(1, 7, 32'h1234);
    tick();
    chk("byp_valid", dif.out_valid, 1);
    chk("byp_rs2", dif.out_rs2_data, 32'h1234);
    set_in(mk(2, 0, 0), 1, 1, 1, 0, 24'h2, 32'h0);
    set_wb(1, 0, 32'hFFFF);
    tick();
    chk("x0_bypass", dif.out_rs1_data, 0);
    set_wb(0, 0, 0);
    set_in(mk(2, 7, 0), 1, 0, 1, 0, 24'h3, 32'h0);
    tick();
    chk("x0_stored", dif.out_rs2_data, 0);
    chk("x7_stored", dif.out_rs1_data, 32'h1234);

    // load-use: one bubble, then issue with the written-back value
    set_in(mk(3, 0, 0), 0, 0, 1, 1, 24'h4, 32'h0);
    tick();
    chk("ld_is_load", dif.out_is_load, 1);
    set_in(mk(4, 3, 0), 1, 0, 1, 0, 24'h5, 32'h0);
    #1 chk("lu_in_ready0", dif.in_ready, 0);
    set_wb(1, 3, 32'h77);
    tick();
    set_wb(0, 0, 0);
    chk("lu_bubble", dif.out_valid, 0);
    #1 chk("lu_in_ready1", dif.in_ready, 1);
    tick();
    chk("lu_issue_valid", dif.out_valid, 1);
    chk("lu_issue_rd", dif.out_rd, 4);
    chk("lu_issue_rs1", dif.out_rs1_data, 32'h77);
`ifdef DECODE_PERF_CNT_EN
    chk("lu_bub_cnt", bub_cnt, 1);
`endif

    // same pair with rs1 unused: no bubble
    set_in(mk(3, 0, 0), 0, 0, 1, 1, 24'h6, 32'h0);
    tick();
    set_in(mk(4, 3, 0), 0, 0, 1, 0, 24'h7, 32'h0);
    #1 chk("nolu_in_ready", dif.in_ready, 1);
    tick();
    chk("nolu_valid", dif.out_valid, 1);
    chk("nolu_rd", dif.out_rd, 4);
    dif.in_valid = 0;
    tick();
    chk("drain_valid", dif.out_valid, 0);

    // downstream stall for 3 cycles with operand refresh
    set_in(mk(2, 9, 0), 1, 0, 1, 0, 24'hABCDE, 32'h5);
    dif.in_valid = 1;
    tick();
    chk("st_valid", dif.out_valid, 1);
    dif.out_ready = 0;
    set_in(mk(5, 1, 1), 1, 1, 1, 0, 24'h999, 32'h0);
    #1 chk("st_in_ready_a", dif.in_ready, 0);
    tick();
    chk("st1_valid", dif.out_valid, 1);
    chk("st1_rs1", dif.out_rs1_data, 0);
    set_wb(1, 9, 32'hBEEF);
    #1 chk("st_in_ready_b", dif.in_ready, 0);
    tick();
    set_wb(0, 0, 0);
    chk("st2_rs1", dif.out_rs1_data, 32'hBEEF);
    chk("st2_ctrl", dif.out_ctrl, 24'hABCDE);
    chk("st2_rd", dif.out_rd, 2);
    chk("st2_imm", dif.out_imm, 32'h5);
    tick();
    chk("st3_valid", dif.out_valid, 1);
    chk("st3_rs1", dif.out_rs1_data, 32'hBEEF);
    chk("st3_in_ready", dif.in_ready, 0);
`ifdef DECODE_PERF_CNT_EN
    chk("st_stall_cnt", stall_cnt, 3);
`endif
    dif.out_ready = 1;
    dif.in_valid  = 0;
    tick();
    chk("st_release", dif.out_valid, 0);

    // flush with a held load and a dependent instruction waiting
    set_in(mk(3, 0, 0), 0, 0, 1, 1, 24'h8, 32'h0);
    dif.in_valid = 1;
    tick();
    dif.out_ready = 0;
    set_in(mk(4, 3, 0), 1, 0, 1, 0, 24'h9, 32'h0);
    dif.flush = 1;
    #1 chk("fl_in_ready", dif.in_ready, 1);
    tick();
    dif.flush = 0;
    dif.in_valid = 0;
    chk("fl_valid", dif.out_valid, 0);
`ifdef DECODE_PERF_CNT_EN
    chk("fl_bub_cnt", bub_cnt, 1);
    chk("fl_stall_cnt", stall_cnt, 4);
`endif
    dif.out_ready = 1;

    // NREGS=16: upper field bit ignored, x15 reachable
    dif16.wb_en = 1; dif16.wb_addr = 4'd3; dif16.wb_data = 32'h33;
    tick();
    dif16.wb_addr = 4'd15; dif16.wb_data = 32'hCAFE;
    dif16.instr = {7'b0, 5'b01111, 5'b10011, 3'b0, 5'd1, 7'h33};
    dif16.rs1_used = 1; dif16.rs2_used = 1; dif16.rd_we_d = 1;
    dif16.in_valid = 1;
    tick();
    chk("n16_valid", dif16.out_valid, 1);
    chk("n16_rs1", dif16.out_rs1_data, 32'h33);
    chk("n16_rs1_addr", dif16.out_rs1_addr, 3);
    chk("n16_rs2_byp", dif16.out_rs2_data, 32'hCAFE);
    dif16.wb_en = 0;
    dif16.instr = {7'b0, 5'b00000, 5'b11111, 3'b0, 5'd1, 7'h33};
    tick();
    chk("n16_x15", dif16.out_rs1_data, 32'hCAFE);
    dif16.in_valid = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/decode_issue_stage.md
Name: decode_issue_stage

Overview:
- Parametrised successor to the combinational decode stage.
- Holds a parametrised register file with write-back bypass and detects load-use hazards.
- Inserts bubbles and owns the registered ID/EX pipeline boundary, with a valid/ready handshake, stall and flush.
- Sits between the fetch/IF-ID register and the execute stage. Control bundle and immediate come from the existing control unit and immediate generator.

Parameters:
- XLEN, 32, datapath and register width.
- NREGS, 32, architectural register count; 16 or 32 only. AW = log2(NREGS).
- CTRL_W, 24, width of the opaque control bundle passed through to execute.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  decode-side instruction valid
- in_ready  out  1  decode-side instruction accepted this cycle
- instr  in  32  instruction; rs1=[19:15], rs2=[24:20], rd=[11:7], low AW bits used
- ctrl_d  in  CTRL_W  control bundle from control unit
- imm_d  in  XLEN  immediate from immediate generator
- rs1_used, rs2_used  in  1 each  source operand read enables
- rd_we_d  in  1  instruction writes rd
- is_load_d  in  1  instruction is a load
- wb_en  in  1  write-back enable
- wb_addr  in  AW  write-back address
- wb_data  in  XLEN  write-back data
- flush  in  1  squash ID/EX and decode-side instruction
- out_ready  in  1  execute accepts ID/EX contents
- out_valid  out  1  ID/EX holds a valid instruction
- out_ctrl  out  CTRL_W  registered control bundle
- out_rs1_data, out_rs2_data  out  XLEN each  registered operands
- out_imm  out  XLEN  registered immediate
- out_rs1_addr, out_rs2_addr, out_rd  out  AW each  registered addresses
- out_rd_we, out_is_load  out  1 each  registered flags

Behaviour:
- Reset (rst=1 at clk edge):
  - All NREGS registers clear to 0.
  - out_valid=0 and all out_* fields clear to 0.
  - Perf counters, if present, clear to 0.
- Register file:
  - Write on clk edge when wb_en=1 and wb_addr!=0.
  - x0 always reads 0.
  - Reads are combinational from instr fields.
  - Bypass: if wb_en=1, wb_addr==rsN and rsN!=0, read data is wb_data the same cycle.
- Hazard signals:
  - advance = ~out_valid | out_ready
  - hazard = in_valid & out_valid & out_is_load & out_rd_we & (out_rd!=0) & ((rs1_used & rs1==out_rd) | (rs2_used & rs2==out_rd))
- Handshake:
  - in_ready = flush | (advance & ~hazard).
  - Accept occurs when in_valid & in_ready.
- ID/EX update, in priority order at each clk edge:
  1. rst
  2. flush: out_valid<=0; the decode-side instruction is consumed and discarded.
  3. advance & in_valid & ~hazard: capture all fields; out_valid<=1. Latency decode→out_valid is one cycle.
  4. advance otherwise (no input or hazard): out_valid<=0, i.e. a bubble. Payload fields are don't-care but hold their old values.
  5. ~advance (held): fields hold, except operand refresh.
- Operand refresh while held: if wb_en, wb_addr!=0 and wb_addr==out_rs1_addr, out_rs1_data<=wb_data. Same rule for rs2. This prevents stale operands during a downstream stall.
- Load-use:
  - Exactly one bubble is inserted per dependent instruction.
  - The next cycle the load has left ID/EX, so hazard clears and the instruction issues.
- Simultaneous events:
  - flush and hazard together: flush wins.
  - flush with out_ready=0: still clears out_valid.
  - wb write to rd and a read of rd in the same cycle: bypass applies.
- out_valid=1 with out_ready=0 must hold all outputs stable, except operand refresh.

Optional Feature:
- Macro DECODE_PERF_CNT_EN.
- When defined, adds outputs perf_stall_cnt [31:0] and perf_bubble_cnt [31:0].
  - perf_stall_cnt increments each cycle out_valid & ~out_ready.
  - perf_bubble_cnt increments each cycle a hazard bubble is inserted (advance & hazard & ~flush).
  - Both counters wrap at 2^32 and clear on rst.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then read-after-write:
  - Stimulus: rst 2 cycles; wb x5=0x0000_00AA; next cycle issue add with rs1=5, rs2=0.
  - Required: out_valid=1 one cycle later, out_rs1_data=0xAA, out_rs2_data=0.
- Same-cycle bypass:
  - Stimulus: wb_en=1, wb_addr=7, wb_data=0x1234 in the same cycle an instr with rs2=7 is accepted.
  - Required: out_rs2_data=0x1234.
  - Also: a wb to x0 of 0xFFFF leaves x0 reads at 0.
- Load-use:
  - Stimulus: issue a load with rd=3, then an add with rs1=3, out_ready=1.
  - Required: in_ready=0 for one cycle and out_valid=0 (bubble).
  - Then the add issues; perf_bubble_cnt=1.
  - Repeat with rs1_used=0: no bubble.
- Downstream stall with refresh:
  - Stimulus: ID/EX holds an instr with rs1=9, out_ready=0 for 3 cycles; during the stall, wb x9=0xBEEF.
  - Required: outputs stable, except out_rs1_data becomes 0xBEEF; in_ready=0 throughout; perf_stall_cnt=3.
- Flush:
  - Stimulus: flush=1 with out_valid=1, out_ready=0, and a hazard active.
  - Required: in_ready=1, and out_valid=0 next cycle.
- NREGS=16 build:
  - Stimulus: instr rs1 field 5'b10011.
  - Required: reads x3; the write at wb_addr=15 is observed.
